// File: rtl/first_counter_pkg.sv
// Shared constants and helpers for first_counter: the default width and the
// all-ones terminal count derived from a given width.
package first_counter_pkg;

  localparam int FIRST_COUNTER_WIDTH = 4;

  // Terminal count 2^width-1; widths above 31 are not supported.
  function automatic logic [31:0] max_count(input int unsigned width);
    max_count = (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/first_counter.sv
// WIDTH-bit up-counter with count enable and a sticky overflow flag.
// Build option FIRST_COUNTER_SATURATE_EN: hold at the maximum instead of wrapping.
module first_counter
  import first_counter_pkg::*;
#(
  parameter int WIDTH = FIRST_COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] counter_out,
  output logic             overflow_out
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(max_count(WIDTH));

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             at_max_s;

  assign at_max_s = (count_q == MAX_COUNT);

  // Next-state: advance on enable; the terminal-count edge sets the sticky flag.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (enable) begin
      if (at_max_s) begin
`ifdef FIRST_COUNTER_SATURATE_EN
        count_d = count_q;
`else
        count_d = '0;
`endif
        ovf_d   = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1'b1);
        ovf_d   = ovf_q;
      end
    end else begin
      count_d = count_q;
      ovf_d   = ovf_q;
    end
  end

  // State registers with synchronous active-low reset taking priority over enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign counter_out  = count_q;
  assign overflow_out = ovf_q;

endmodule

// File: tb/tb_first_counter.sv
// Self-checking bench for first_counter: directed scenarios plus randomized
// enable/reset traffic checked against an arithmetic reference model.
module tb_first_counter;

  localparam int W      = 4;
  localparam int MODULO = 1 << W;
  localparam int MAXV   = MODULO - 1;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [W-1:0] counter_out;
  logic         overflow_out;

  int checks   = 0;
  int failures = 0;
  int mc       = 0;
  int mo       = 0;

  first_counter #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .counter_out (counter_out),
    .overflow_out(overflow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one clock edge with the given inputs, advance the model, sample 1ns later.
  task automatic step(input logic en, input logic rst_n);
    int nxt;
    enable = en;
    reset  = rst_n;
    @(posedge clk);
    if (!rst_n) begin
      mc = 0;
      mo = 0;
    end else if (en) begin
      nxt = mc + 1;
      if (nxt >= MODULO) mo = 1;
`ifdef FIRST_COUNTER_SATURATE_EN
      mc = (nxt > MAXV) ? MAXV : nxt;
`else
      mc = nxt % MODULO;
`endif
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0);
    checks++;
    if (counter_out !== W'(0) || overflow_out !== 1'b0) begin
      failures++;
      $display("FAIL reset: counter_out=%0d overflow_out=%0b expected 0/0", counter_out, overflow_out);
    end
    step(1'b0, 1'b0);
    checks++;
    if (counter_out !== W'(0) || overflow_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: counter_out=%0d overflow_out=%0b expected 0/0", counter_out, overflow_out);
    end
  endtask

  task automatic test_count();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    checks++;
    if (counter_out !== W'(10) || overflow_out !== 1'b0) begin
      failures++;
      $display("FAIL count10: counter_out=%0d overflow_out=%0b expected 10/0", counter_out, overflow_out);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if (counter_out !== W'(10) || overflow_out !== 1'b0) begin
        failures++;
        $display("FAIL count_hold: counter_out=%0d overflow_out=%0b expected 10/0", counter_out, overflow_out);
      end
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b1);
      checks++;
      if (counter_out !== W'(mc) || overflow_out !== mo[0]) begin
        failures++;
        $display("FAIL wrap_edge%0d: counter_out=%0d overflow_out=%0b expected %0d/%0d",
                 i, counter_out, overflow_out, mc, mo);
      end
    end
`ifdef FIRST_COUNTER_SATURATE_EN
    checks++;
    if (counter_out !== W'(15) || overflow_out !== 1'b1) begin
      failures++;
      $display("FAIL sat16: counter_out=%0d overflow_out=%0b expected 15/1", counter_out, overflow_out);
    end
`else
    checks++;
    if (counter_out !== W'(0) || overflow_out !== 1'b1) begin
      failures++;
      $display("FAIL wrap16: counter_out=%0d overflow_out=%0b expected 0/1", counter_out, overflow_out);
    end
`endif
  endtask

  task automatic test_sticky();
    for (int i = 17; i <= 100; i++) begin
      step(1'b1, 1'b1);
      checks++;
      if (counter_out !== W'(mc) || overflow_out !== 1'b1) begin
        failures++;
        $display("FAIL sticky_edge%0d: counter_out=%0d overflow_out=%0b expected %0d/1",
                 i, counter_out, overflow_out, mc);
      end
    end
`ifndef FIRST_COUNTER_SATURATE_EN
    checks++;
    if (counter_out !== W'(4)) begin
      failures++;
      $display("FAIL sticky100: counter_out=%0d expected 4", counter_out);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if (counter_out !== W'(mc) || overflow_out !== 1'b1) begin
        failures++;
        $display("FAIL sticky_hold: counter_out=%0d overflow_out=%0b expected %0d/1",
                 counter_out, overflow_out, mc);
      end
    end
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
`ifndef FIRST_COUNTER_SATURATE_EN
    checks++;
    if (counter_out !== W'(7) || overflow_out !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: counter_out=%0d overflow_out=%0b expected 7/1", counter_out, overflow_out);
    end
`endif
    step(1'b1, 1'b0);
    checks++;
    if (counter_out !== W'(0) || overflow_out !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: counter_out=%0d overflow_out=%0b expected 0/0", counter_out, overflow_out);
    end
    step(1'b1, 1'b1);
    checks++;
    if (counter_out !== W'(1) || overflow_out !== 1'b0) begin
      failures++;
      $display("FAIL resume: counter_out=%0d overflow_out=%0b expected 1/0", counter_out, overflow_out);
    end
  endtask

  // Max count with enable low must not set the flag.
  task automatic test_max_idle();
    step(1'b1, 1'b0);
    for (int i = 0; i < MAXV; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if (counter_out !== W'(MAXV) || overflow_out !== 1'b0) begin
        failures++;
        $display("FAIL max_idle: counter_out=%0d overflow_out=%0b expected %0d/0",
                 counter_out, overflow_out, MAXV);
      end
    end
  endtask

  task automatic test_random();
    logic en;
    logic rn;
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      rn = ($urandom_range(0, 39) != 0);
      step(en, rn);
      checks++;
      if (counter_out !== W'(mc) || overflow_out !== mo[0]) begin
        failures++;
        $display("FAIL random%0d: counter_out=%0d overflow_out=%0b expected %0d/%0d",
                 i, counter_out, overflow_out, mc, mo);
      end
    end
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    test_reset();
    test_count();
    test_wrap();
    test_sticky();
    test_midreset();
    test_max_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
